// File: rtl/mcu_spi_slave_pkg.sv
// Shared constants and types for the MCU SPI slave front end.
package mcu_spi_slave_pkg;

   localparam int unsigned SPI_BITS = 8;
   localparam int unsigned BIT_CNT_W = $clog2(SPI_BITS);
   localparam int unsigned BYTE_CNT_W = 8;
   localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;

   // SCK edge on which MOSI is sampled; MISO shifts on the opposite edge
   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_FALL = 1'b1
   } edge_sel_e;

   localparam edge_sel_e MODE0_SAMPLE_EDGE = EDGE_RISE;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/mcu_spi_slave_spi_input_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin plus edge detector.
module spi_input_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchroniser and keep the previous settled value
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave: oversampled receive into bytes, one-byte-delayed response on MISO.
module mcu_spi_slave
   import mcu_spi_slave_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_csn,
   input  logic                  spi_sck,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic                  data_in_strobe,
   output logic                  data_in_start,
   output logic [SPI_BITS-1:0]   data_in,
   input  logic [SPI_BITS-1:0]   data_out,
   output logic                  frame_err,
   output logic [BYTE_CNT_W-1:0] byte_count
);

   logic csn_level, csn_rise, csn_fall;
   logic sck_level, sck_rise, sck_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
      .clk(clk), .reset(reset), .pin(spi_csn),
      .level(csn_level), .rise(csn_rise), .fall(csn_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .reset(reset), .pin(spi_sck),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .reset(reset), .pin(spi_mosi),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

   logic sample_edge, shift_edge;
   assign sample_edge = (MODE0_SAMPLE_EDGE == EDGE_RISE) ? sck_rise : sck_fall;
   assign shift_edge  = (MODE0_SAMPLE_EDGE == EDGE_RISE) ? sck_fall : sck_rise;

   spi_state_e state_q, state_d;

   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SPI_BITS-2:0]   rx_q, rx_d;
   logic [SPI_BITS-1:0]   tx_q, tx_d;
   logic                  first_q, first_d;
   logic                  armed_q, armed_d;
   logic                  load_pend_q, load_pend_d;
   logic [BYTE_CNT_W-1:0] byte_count_d;
   logic [SPI_BITS-1:0]   data_in_d;
   logic                  strobe_d, start_d, frame_err_d, oe_d;

   logic start_txn, end_txn, in_active;
   assign start_txn = (state_q == ST_IDLE) && csn_fall && armed_q;
   assign end_txn   = (state_q == ST_ACTIVE) && csn_rise;
   assign in_active = (state_q == ST_ACTIVE) && !csn_rise && !csn_fall;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: enter on an armed CSn fall, leave on CSn rise
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_txn) state_d = ST_ACTIVE;
         ST_ACTIVE: if (end_txn)   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values of the datapath and registered outputs
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      first_d      = first_q;
      armed_d      = armed_q | csn_level;
      load_pend_d  = load_pend_q;
      byte_count_d = byte_count;
      data_in_d    = data_in;
      strobe_d     = 1'b0;
      start_d      = 1'b0;
      frame_err_d  = 1'b0;
      oe_d         = spi_miso_oe;

      if (start_txn) begin
         bit_cnt_d    = '0;
         first_d      = 1'b1;
         byte_count_d = '0;
         tx_d         = '0;
         load_pend_d  = 1'b0;
         oe_d         = 1'b1;
      end else if (end_txn) begin
         // A partial byte is dropped silently apart from the error pulse
         frame_err_d = (bit_cnt_q != '0);
         bit_cnt_d   = '0;
         load_pend_d = 1'b0;
         oe_d        = 1'b0;
      end else if (in_active) begin
         if (sample_edge) begin
            rx_d      = {rx_q[SPI_BITS-3:0], mosi_level};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(SPI_BITS - 1)) begin
               data_in_d   = {rx_q, mosi_level};
               strobe_d    = 1'b1;
               start_d     = first_q;
               first_d     = 1'b0;
               load_pend_d = 1'b1;
               if (byte_count != BYTE_CNT_MAX)
                  byte_count_d = byte_count + BYTE_CNT_W'(1);
            end
         end
         if (shift_edge) begin
            if (load_pend_q) begin
               tx_d        = data_out;
               load_pend_d = 1'b0;
            end else begin
               tx_d = {tx_q[SPI_BITS-2:0], 1'b0};
            end
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_q      <= '0;
         rx_q           <= '0;
         tx_q           <= '0;
         first_q        <= 1'b1;
         armed_q        <= 1'b0;
         load_pend_q    <= 1'b0;
         byte_count     <= '0;
         data_in        <= '0;
         data_in_strobe <= 1'b0;
         data_in_start  <= 1'b0;
         frame_err      <= 1'b0;
         spi_miso_oe    <= 1'b0;
      end else begin
         bit_cnt_q      <= bit_cnt_d;
         rx_q           <= rx_d;
         tx_q           <= tx_d;
         first_q        <= first_d;
         armed_q        <= armed_d;
         load_pend_q    <= load_pend_d;
         byte_count     <= byte_count_d;
         data_in        <= data_in_d;
         data_in_strobe <= strobe_d;
         data_in_start  <= start_d;
         frame_err      <= frame_err_d;
         spi_miso_oe    <= oe_d;
      end
   end

   assign spi_miso = tx_q[SPI_BITS-1];

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Randomised bench for mcu_spi_slave with a transaction-level reference model.
module tb_mcu_spi_slave;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_csn = 1'b1;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       spi_miso, spi_miso_oe, data_in_strobe, data_in_start, frame_err;
   logic [7:0] data_in, byte_count;

   always #5 clk = ~clk;

   mcu_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
      .data_in(data_in), .data_out(data_out),
      .frame_err(frame_err), .byte_count(byte_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected strobe events, in order
   typedef struct {
      logic [7:0] d;
      logic       st;
      logic [7:0] cnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] resp_q[$];
   logic [7:0] resp_plan[$];
   int         fe_pending = 0;

   // Transaction-level model of the slave as seen from the pins
   bit m_armed  = 1'b0;
   bit m_active = 1'b0;
   bit m_first  = 1'b0;
   int m_count  = 0;
   int m_bits   = 0;

   logic       rst_q = 1'b0;
   logic [7:0] last_din = 8'h00;

   always @(posedge clk) rst_q <= reset;

   // Per-cycle checker: reset values, strobes against the model, hold behaviour
   always @(negedge clk) begin
      if (rst_q) begin
         chk("rst_strobe", 32'(data_in_strobe), 32'd0);
         chk("rst_data_in", 32'(data_in), 32'h00);
         chk("rst_frame_err", 32'(frame_err), 32'd0);
         chk("rst_byte_count", 32'(byte_count), 32'd0);
         chk("rst_miso", 32'(spi_miso), 32'd0);
         chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
         last_din = 8'h00;
      end else begin
         if (data_in_strobe) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'(data_in_strobe), 32'd0);
            end else begin
               exp_t e;
               logic [7:0] r;
               e = exp_q.pop_front();
               chk("data_in", 32'(data_in), 32'(e.d));
               chk("data_in_start", 32'(data_in_start), 32'(e.st));
               chk("byte_count", 32'(byte_count), 32'(e.cnt));
               r = (resp_plan.size() != 0) ? resp_plan.pop_front() : 8'($urandom);
               data_out = r;
               resp_q.push_back(r);
            end
            last_din = data_in;
         end else begin
            chk("data_in_hold", 32'(data_in), 32'(last_din));
            chk("start_without_strobe", 32'(data_in_start), 32'd0);
         end
         if (frame_err) begin
            if (fe_pending > 0) fe_pending--;
            else chk("unexpected_frame_err", 32'(frame_err), 32'd0);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCK period: falling edge with new MOSI, then rising edge; returns MISO seen before the rise
   task automatic send_bit(input bit b, output bit miso_s);
      spi_sck  = 1'b0;
      spi_mosi = b;
      wait_clk(4);
      miso_s  = spi_miso;
      spi_sck = 1'b1;
      wait_clk(4);
   endtask

   // Full byte; the model records the expected strobe before the last rising edge
   task automatic send_byte(input logic [7:0] b, output logic [7:0] rx);
      bit s;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && m_active) begin
            m_count = (m_count < 255) ? m_count + 1 : 255;
            exp_q.push_back('{d: b, st: m_first, cnt: 8'(m_count)});
            m_first = 1'b0;
         end
         send_bit(b[i], s);
         rx[i] = s;
      end
   endtask

   // Byte with MISO check: first byte carries 0x00, later ones the previous response
   task automatic xfer(input logic [7:0] b, output logic [7:0] rx);
      bit was_first;
      bit was_active;
      logic [7:0] exp_miso;
      was_first  = m_first;
      was_active = m_active;
      send_byte(b, rx);
      if (was_active) begin
         exp_miso = 8'h00;
         if (!was_first && resp_q.size() != 0) exp_miso = resp_q.pop_front();
         chk("miso_byte", 32'(rx), 32'(exp_miso));
      end
   endtask

   task automatic send_partial(input int n);
      bit s;
      for (int i = 0; i < n; i++) send_bit(1'($urandom), s);
      if (m_active) m_bits = n;
   endtask

   task automatic csn_low();
      spi_csn = 1'b0;
      if (m_armed && !m_active) begin
         m_active = 1'b1;
         m_first  = 1'b1;
         m_count  = 0;
         m_bits   = 0;
      end
      resp_q.delete();
      wait_clk(6);
      chk("miso_oe_select", 32'(spi_miso_oe), 32'(m_active));
   endtask

   task automatic csn_high();
      spi_sck = 1'b0;
      wait_clk(4);
      spi_csn = 1'b1;
      if (m_active && m_bits != 0) fe_pending++;
      m_active = 1'b0;
      m_bits   = 0;
      wait_clk(6);
      m_armed = 1'b1;
      chk("miso_oe_deselect", 32'(spi_miso_oe), 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      int len;

      // Reset with CSn high
      reset = 1'b1;
      wait_clk(5);
      reset = 1'b0;
      wait_clk(8);
      m_armed = 1'b1;

      // SCK activity while deselected: no strobes, MISO stays low
      for (int k = 0; k < 2; k++) begin
         send_byte(8'($urandom), rx);
         chk("idle_miso", 32'(rx), 32'h00);
      end
      spi_sck = 1'b0;
      wait_clk(8);

      // Directed three-byte transaction with fixed responses
      resp_plan.push_back(8'h5C);
      resp_plan.push_back(8'h42);
      csn_low();
      xfer(8'h00, rx);
      chk("dir_miso_slot1", 32'(rx), 32'h00);
      xfer(8'h11, rx);
      chk("dir_miso_slot2", 32'(rx), 32'h5C);
      xfer(8'h22, rx);
      chk("dir_miso_slot3", 32'(rx), 32'h42);
      wait_clk(2);
      chk("dir_data_in_last", 32'(data_in), 32'h22);
      chk("dir_byte_count", 32'(byte_count), 32'd3);
      csn_high();

      // CSn raised mid-byte, then a fresh transaction
      csn_low();
      xfer(8'($urandom), rx);
      send_partial(5);
      csn_high();
      csn_low();
      xfer(8'h3C, rx);
      csn_high();

      // Reset mid-byte with CSn held low: block stays disarmed
      csn_low();
      send_partial(3);
      reset = 1'b1;
      m_active = 1'b0;
      m_armed  = 1'b0;
      m_bits   = 0;
      wait_clk(3);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) send_byte(8'($urandom), rx);
      chk("disarmed_byte_count", 32'(byte_count), 32'd0);
      csn_high();
      csn_low();
      xfer(8'h96, rx);
      csn_high();

      // SCK rise coincident with CSn fall: that bit is dropped
      spi_csn  = 1'b0;
      spi_sck  = 1'b1;
      spi_mosi = 1'b1;
      m_active = 1'b1;
      m_first  = 1'b1;
      m_count  = 0;
      resp_q.delete();
      wait_clk(4);
      xfer(8'hA5, rx);
      wait_clk(2);
      chk("coincident_byte", 32'(data_in), 32'hA5);
      chk("coincident_count", 32'(byte_count), 32'd1);
      csn_high();

      // Random transactions, some ending mid-byte
      for (int t = 0; t < 12; t++) begin
         csn_low();
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) xfer(8'($urandom), rx);
         if ($urandom_range(0, 3) == 0) send_partial($urandom_range(1, 7));
         csn_high();
      end

      // Long transaction: byte_count saturates
      csn_low();
      for (int k = 0; k < 300; k++) xfer(8'($urandom), rx);
      wait_clk(2);
      chk("sat_byte_count", 32'(byte_count), 32'd255);
      csn_high();

      wait_clk(10);
      chk("strobes_outstanding", 32'(exp_q.size()), 32'd0);
      chk("frame_err_outstanding", 32'(fe_pending), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
SPI slave front end between the board MCU's SPI pins and the system control block. It oversamples the MCU's SCK/CSn/MOSI in the core clock domain and delivers each received byte as a one-cycle `data_in_strobe`, with `data_in_start` flagging the first byte of a transaction. It returns the system control block's `data_out` byte serially on MISO during the following byte slot.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on each of spi_sck, spi_csn and spi_mosi (minimum 2).

Ports:
clk  input  1  core clock; must run at least 4x the SCK frequency
reset  input  1  synchronous, active-high reset
spi_csn  input  1  MCU chip select, active low, asynchronous to clk
spi_sck  input  1  MCU serial clock, SPI mode 0 (CPOL=0, CPHA=0), asynchronous
spi_mosi  input  1  serial data from the MCU, MSB first
spi_miso  output  1  serial data to the MCU, MSB first
spi_miso_oe  output  1  MISO output enable; high only while the transaction is selected
data_in_strobe  output  1  one-clk pulse; a complete byte is valid on data_in
data_in_start  output  1  high together with the strobe for the first byte after CSn falls
data_in  output  8  last received byte; held until the next strobe
data_out  input  8  response byte from the system control block; valid from 1 clk after the strobe
frame_err  output  1  one-clk pulse when CSn rises mid-byte
byte_count  output  8  bytes received in the current transaction; saturates at 255

Behaviour:
- Reset values:
  - data_in_strobe=0, data_in_start=0, data_in=0x00, frame_err=0, byte_count=0.
  - spi_miso=0, spi_miso_oe=0.
  - Internal: bit counter=0, tx shift=0x00, first-byte flag=1, armed=0.
- Synchronisation:
  - Each SPI input passes through SYNC_STAGES flip-flops.
  - Edges are detected by comparing the last synchronised value with the previous one.
  - Pin-to-detected-edge latency is SYNC_STAGES+1 clk.
- Arming:
  - After reset the block ignores all SPI activity until synchronised CSn has been seen high for at least 1 clk; it then sets armed=1.
  - This prevents a partial frame after a mid-transaction reset.
- States: IDLE (CSn high), ACTIVE (CSn low, armed).
  - IDLE->ACTIVE on the CSn falling edge. In the same clk: bit counter=0, first-byte flag=1, byte_count=0, tx shift=0x00, spi_miso_oe=1.
  - ACTIVE->IDLE on the CSn rising edge. If bit counter is not 0, pulse frame_err and discard the partial byte with no strobe. Set spi_miso_oe=0.
- Receive:
  - On each SCK rising edge in ACTIVE, shift MOSI into the rx register (MSB first) and increment the bit counter modulo 8.
  - On the 8th bit, in the same clk as the edge detect:
    - data_in = the assembled byte; data_in_strobe=1 for exactly 1 clk.
    - data_in_start = first-byte flag; then clear the flag.
    - byte_count increments, holding at 255.
- Transmit:
  - spi_miso always equals tx_shift[7].
  - On the first SCK falling edge after a byte completes, load tx shift from data_out. That edge is at least 2 clk after the strobe, given the clock ratio rule.
  - On the other falling edges, shift tx left and fill with 0.
  - Response to byte N is therefore transmitted during byte N+1. During the first byte of a transaction MISO outputs 0x00.
- SCK edges while in IDLE, or while not armed, are ignored.
- A CSn falling edge in the same clk as an SCK edge takes priority: the SCK edge is ignored.
- Reset asserted mid-byte: all state returns to reset values immediately, with no strobe or frame_err.

Decomposition:
- Shared package: SPI_BITS=8 and the MODE0 edge-select constant.
- Sub-module spi_input_sync, one instance per SPI input: parameterised synchroniser plus edge detector, with outputs level, rise and fall.

Test Plan:
- Reset, CSn high, then CSn low; send 0x00,0x11,0x22 at clk/8 SCK -> three strobes with data_in 0x00,0x11,0x22; data_in_start=1 only on the first; byte_count=3.
- data_out driven to 0x5C after strobe 1 and 0x42 after strobe 2 -> MISO carries 0x00, 0x5C, 0x42 in byte slots 1, 2, 3.
- CSn raised after 5 bits of a byte -> frame_err pulses once, no strobe, spi_miso_oe=0; the next transaction starts with data_in_start=1.
- Reset asserted mid-byte while CSn stays low, then 16 SCK clocks -> no strobes until CSn rises and falls again.
- SCK toggled with CSn high -> no strobes and MISO stays 0; 300-byte transaction -> byte_count saturates at 255.
- SCK rising edge coincident with the CSn falling edge (same clk after sync) -> that bit ignored; the following 8 bits form byte 0xA5 correctly.
